// File: rtl/conv_adder_tree_acc.sv
// conv_adder_tree_acc: pipelined signed adder tree with channel accumulation,
// bias add, rounding right-shift, optional ReLU and saturation.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_first/in_last        beat qualifier and channel-burst framing
//   product_in[N_IN]                 signed PE products for this beat
//   bias_in                          bias, taken from the first beat of a pixel
//   shift_in, relu_en                post-processing, taken from the last beat
//   out_valid/out_data/out_sat       registered result strobe, value, clip flag
module conv_adder_tree_acc #(
  parameter int unsigned N_IN   = 9,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [IN_W-1:0]   product_in [N_IN],
  input  logic signed [BIAS_W-1:0] bias_in,
  input  logic [4:0]               shift_in,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat
);

  localparam int unsigned T    = $clog2(N_IN);
  localparam int unsigned D    = T + 1;      // leaf register + T tree levels
  localparam int unsigned SH_W = 5;
  localparam int unsigned RW   = ACC_W + 1;  // headroom for the rounding add

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Live node count at a given tree level (ceil(N_IN / 2^lvl)).
  function automatic int unsigned nodes_at(input int unsigned lvl);
    return (N_IN + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // Tree data: level 0 holds sign-extended leaves, level T holds the beat sum.
  logic signed [ACC_W-1:0] node_q [D][N_IN];

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < N_IN; j++) begin
      node_q[0][j] <= {{(ACC_W-IN_W){product_in[j][IN_W-1]}}, product_in[j]};
    end
    for (int unsigned l = 1; l < D; l++) begin
      for (int unsigned j = 0; j < N_IN; j++) begin
        if (2*j + 1 < nodes_at(l-1)) begin
          node_q[l][j] <= node_q[l-1][2*j] + node_q[l-1][2*j+1];
        end else if (2*j < nodes_at(l-1)) begin
          node_q[l][j] <= node_q[l-1][2*j];   // odd leftover passes through
        end else begin
          node_q[l][j] <= '0;
        end
      end
    end
  end

  // Sideband pipe kept in step with the tree data.
  logic                     sb_valid_q [D];
  logic                     sb_first_q [D];
  logic                     sb_last_q  [D];
  logic                     sb_relu_q  [D];
  logic signed [BIAS_W-1:0] sb_bias_q  [D];
  logic [SH_W-1:0]          sb_shift_q [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < D; k++) begin
        sb_valid_q[k] <= 1'b0;
        sb_first_q[k] <= 1'b0;
        sb_last_q[k]  <= 1'b0;
        sb_relu_q[k]  <= 1'b0;
        sb_bias_q[k]  <= '0;
        sb_shift_q[k] <= '0;
      end
    end else begin
      sb_valid_q[0] <= in_valid;
      sb_first_q[0] <= in_first;
      sb_last_q[0]  <= in_last;
      sb_relu_q[0]  <= relu_en;
      sb_bias_q[0]  <= bias_in;
      sb_shift_q[0] <= shift_in;
      for (int unsigned k = 1; k < D; k++) begin
        sb_valid_q[k] <= sb_valid_q[k-1];
        sb_first_q[k] <= sb_first_q[k-1];
        sb_last_q[k]  <= sb_last_q[k-1];
        sb_relu_q[k]  <= sb_relu_q[k-1];
        sb_bias_q[k]  <= sb_bias_q[k-1];
        sb_shift_q[k] <= sb_shift_q[k-1];
      end
    end
  end

  logic                    fin_valid, fin_first, fin_last, fin_relu;
  logic [SH_W-1:0]         fin_shift;
  logic signed [ACC_W-1:0] acc_q, bias_q, fin_bias, sum_c, r_c;
  logic signed [RW-1:0]    r_ext, rnd, post;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;

  assign fin_valid = sb_valid_q[D-1];
  assign fin_first = sb_first_q[D-1];
  assign fin_last  = sb_last_q[D-1];
  assign fin_relu  = sb_relu_q[D-1];
  assign fin_shift = sb_shift_q[D-1];
  assign fin_bias  = {{(ACC_W-BIAS_W){sb_bias_q[D-1][BIAS_W-1]}}, sb_bias_q[D-1]};

  // Accumulate / bias / round / ReLU / saturate for the beat leaving the tree.
  always_comb begin
    sum_c    = (fin_first ? '0 : acc_q) + node_q[T][0];
    r_c      = sum_c + (fin_first ? fin_bias : bias_q);
    r_ext    = {r_c[ACC_W-1], r_c};
    rnd      = '0;
    post     = r_ext;
    sat_data = '0;
    sat_flag = 1'b0;
    if (32'(fin_shift) >= ACC_W) begin
      post = r_c[ACC_W-1] ? '1 : '0;
    end else if (fin_shift != '0) begin
      rnd  = RW'(1) << (fin_shift - SH_W'(1));
      post = (r_ext + rnd) >>> fin_shift;
    end
    if (fin_relu && post[RW-1]) begin
      post = '0;
    end
    if (post > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (post < SAT_MIN) begin
      sat_data = SAT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end else begin
      sat_data = post[OUT_W-1:0];
    end
  end

  // Channel accumulator and the bias captured on the pixel's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
    end else if (fin_valid) begin
      if (fin_last) begin
        acc_q  <= '0;
        bias_q <= '0;
      end else begin
        acc_q <= sum_c;
        if (fin_first) begin
          bias_q <= fin_bias;
        end
      end
    end
  end

  logic                    out_valid_q, out_sat_q;
  logic signed [OUT_W-1:0] out_data_q;

  // Result register; data and flag hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= fin_valid & fin_last;
      if (fin_valid && fin_last) begin
        out_data_q <= sat_data;
        out_sat_q  <= sat_flag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
